alu_register_unit: RTL and testbench

//  Datapath primitive pair for the small CPU: a combinational 8-op ALU and an

---
 rtl/alu_register_unit_pkg.sv | 14 +
 rtl/alu_register_unit_if.sv | 32 +++
 rtl/alu_register_unit_alu.sv | 32 +++
 rtl/alu_register_unit_reg.sv | 40 ++++
 rtl/alu_register_unit.sv | 33 +++
 tb/tb_alu_register_unit.sv | 128 ++++++++++++
 6 files changed

// File: rtl/alu_register_unit_pkg.sv
// Shared opcode encodings and default width for the ALU/register datapath pair.
// No timing or flow-control content; constants only.
package alu_register_unit_pkg;
    localparam int DATA_WIDTH_DEF = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;
endpackage

// File: rtl/alu_register_unit_if.sv
// Bundles ALU operands/result and register controls/contents for the datapath pair.
// Latency: none of its own; backpressure: none, every signal is sampled or driven unconditionally.
interface alu_register_unit_if #(
    parameter int DATA_WIDTH = alu_register_unit_pkg::DATA_WIDTH_DEF
);
    logic [2:0]            alu_oc;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_f;
    logic                  reg_cl;
    logic                  reg_ld;
    logic [DATA_WIDTH-1:0] reg_in;
    logic                  reg_inc;
    logic                  reg_dec;
    logic                  reg_sr;
    logic                  reg_ir;
    logic                  reg_sl;
    logic                  reg_il;
    logic [DATA_WIDTH-1:0] reg_out;

    modport master (
        output alu_oc, alu_a, alu_b,
        output reg_cl, reg_ld, reg_in, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il,
        input  alu_f, reg_out
    );

    modport slave (
        input  alu_oc, alu_a, alu_b,
        input  reg_cl, reg_ld, reg_in, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il,
        output alu_f, reg_out
    );
endinterface

// File: rtl/alu_register_unit_alu.sv
// alu4_core: 8-op combinational ALU, results truncated to DATA_WIDTH.
// Latency: zero cycles; backpressure: none.
module alu4_core
    import alu_register_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [2:0]            oc_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] f_o
);
    logic [2*DATA_WIDTH-1:0] prod;

    assign prod = a_i * b_i;

    always_comb begin
        f_o = '0;
        unique case (oc_i)
            OP_ADD: f_o = a_i + b_i;
            OP_SUB: f_o = a_i - b_i;
            OP_MUL: f_o = prod[DATA_WIDTH-1:0];
            // Divide-by-zero yields zero rather than X so downstream never sees unknowns.
            OP_DIV: f_o = (b_i == '0) ? '0 : a_i / b_i;
            OP_NOT: f_o = ~a_i;
            OP_XOR: f_o = a_i ^ b_i;
            OP_OR:  f_o = a_i | b_i;
            OP_AND: f_o = a_i & b_i;
            default: f_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_register_unit_reg.sv
// shift_reg_core: register with priority clear > load > inc > dec > shr > shl > hold.
// Latency: one clock to reg_out; backpressure: none.
module shift_reg_core
    import alu_register_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cl_i,
    input  logic                  ld_i,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic                  inc_i,
    input  logic                  dec_i,
    input  logic                  sr_i,
    input  logic                  ir_i,
    input  logic                  sl_i,
    input  logic                  il_i,
    output logic [DATA_WIDTH-1:0] out_o
);
    logic [DATA_WIDTH-1:0] reg_d;
    logic [DATA_WIDTH-1:0] reg_q;

    always_comb begin
        reg_d = reg_q;
        if (cl_i)       reg_d = '0;
        else if (ld_i)  reg_d = in_i;
        else if (inc_i) reg_d = reg_q + 1'b1;
        else if (dec_i) reg_d = reg_q - 1'b1;
        else if (sr_i)  reg_d = {ir_i, reg_q[DATA_WIDTH-1:1]};
        else if (sl_i)  reg_d = {reg_q[DATA_WIDTH-2:0], il_i};
    end

    always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
    end

    assign out_o = reg_q;
endmodule

// File: rtl/alu_register_unit.sv
// Top: wires the independent combinational ALU and the clocked register to the bus.
// Latency: ALU zero cycles, register one cycle; backpressure: none.
module alu_register_unit
    import alu_register_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    alu_register_unit_if.slave bus
);
    alu4_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .oc_i (bus.alu_oc),
        .a_i  (bus.alu_a),
        .b_i  (bus.alu_b),
        .f_o  (bus.alu_f)
    );

    shift_reg_core #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
        .clk   (clk),
        .rst   (rst),
        .cl_i  (bus.reg_cl),
        .ld_i  (bus.reg_ld),
        .in_i  (bus.reg_in),
        .inc_i (bus.reg_inc),
        .dec_i (bus.reg_dec),
        .sr_i  (bus.reg_sr),
        .ir_i  (bus.reg_ir),
        .sl_i  (bus.reg_sl),
        .il_i  (bus.reg_il),
        .out_o (bus.reg_out)
    );
endmodule

// File: tb/tb_alu_register_unit.sv
// Directed and exhaustive checks of the ALU plus directed/random checks of the register.
module tb_alu_register_unit;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    alu_register_unit_if #(.DATA_WIDTH(W)) bus ();

    alu_register_unit #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(input logic [2:0] oc, input logic [W-1:0] a, b);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
        case (oc)
            3'd0: return W'(a + b);
            3'd1: return W'(a - b);
            3'd2: return p[W-1:0];
            3'd3: return (b == 0) ? '0 : W'(a / b);
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [2:0] oc, input logic [W-1:0] a, b,
                           input logic [W-1:0] exp);
        bus.alu_oc = oc; bus.alu_a = a; bus.alu_b = b;
        #1;
        chk(tag, bus.alu_f, exp);
    endtask

    // Apply one set of controls across a rising edge, then sample 1 time unit later.
    task automatic cyc(input logic r, cl, ld, inc, dec, sr, ir, sl, il, input logic [W-1:0] din);
        rst = r; bus.reg_cl = cl; bus.reg_ld = ld; bus.reg_inc = inc; bus.reg_dec = dec;
        bus.reg_sr = sr; bus.reg_ir = ir; bus.reg_sl = sl; bus.reg_il = il; bus.reg_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] m;
        logic r, cl, ld, inc, dec, sr, ir, sl, il;
        logic [W-1:0] din;

        rst = 1'b1;
        bus.alu_oc = '0; bus.alu_a = '0; bus.alu_b = '0;
        bus.reg_cl = 0; bus.reg_ld = 0; bus.reg_in = '0; bus.reg_inc = 0; bus.reg_dec = 0;
        bus.reg_sr = 0; bus.reg_ir = 0; bus.reg_sl = 0; bus.reg_il = 0;

        alu_vec("add_wrap", 3'b000, 4'b1001, 4'b1000, 4'b0001);
        alu_vec("sub_wrap", 3'b001, 4'b0010, 4'b0101, 4'b1101);
        alu_vec("mul_low",  3'b010, 4'b0111, 4'b0011, 4'b0101);
        alu_vec("div",      3'b011, 4'b1101, 4'b0100, 4'b0011);
        alu_vec("div_zero", 3'b011, 4'b1011, 4'b0000, 4'b0000);
        alu_vec("not",      3'b100, 4'b1010, 4'b0110, 4'b0101);
        alu_vec("xor",      3'b101, 4'b1100, 4'b1010, 4'b0110);
        alu_vec("or",       3'b110, 4'b1100, 4'b1010, 4'b1110);
        alu_vec("and",      3'b111, 4'b1100, 4'b1010, 4'b1000);

        for (int i = 0; i < 2048; i++) begin
            logic [10:0] v;
            v = 11'(i);
            alu_vec($sformatf("alu_exh oc=%0d a=%0d b=%0d", v[10:8], v[7:4], v[3:0]),
                    v[10:8], v[7:4], v[3:0], alu_ref(v[10:8], v[7:4], v[3:0]));
        end

        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1010); chk("reset_over_ld", bus.reg_out, 4'b0000);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1010); chk("load", bus.reg_out, 4'b1010);
        cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000); chk("shr_ir1", bus.reg_out, 4'b1101);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1010);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000); chk("shl_il1", bus.reg_out, 4'b0101);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1010);
        cyc(0, 0, 0, 0, 0, 1, 1, 1, 1, 4'b0000); chk("shr_over_shl", bus.reg_out, 4'b1101);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, 4'b1111); chk("cl_over_ld_inc", bus.reg_out, 4'b0000);
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0110); chk("ld_over_inc", bus.reg_out, 4'b0110);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0011);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'b0000); chk("inc_over_dec", bus.reg_out, 4'b0100);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1111);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000); chk("inc_wrap", bus.reg_out, 4'b0000);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000); chk("dec_wrap", bus.reg_out, 4'b1111);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000); chk("hold", bus.reg_out, 4'b1111);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000); chk("reset_mid_seq", bus.reg_out, 4'b0000);

        m = '0;
        for (int n = 0; n < 1000; n++) begin
            r   = ($urandom_range(0, 31) == 0);
            cl  = ($urandom_range(0, 15) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            inc = $urandom_range(0, 1) == 1;
            dec = $urandom_range(0, 1) == 1;
            sr  = $urandom_range(0, 1) == 1;
            ir  = $urandom_range(0, 1) == 1;
            sl  = $urandom_range(0, 1) == 1;
            il  = $urandom_range(0, 1) == 1;
            din = W'($urandom);
            if (r)        m = '0;
            else if (cl)  m = '0;
            else if (ld)  m = din;
            else if (inc) m = m + 1'b1;
            else if (dec) m = m - 1'b1;
            else if (sr)  m = {ir, m[W-1:1]};
            else if (sl)  m = {m[W-2:0], il};
            cyc(r, cl, ld, inc, dec, sr, ir, sl, il, din);
            chk($sformatf("rand_cycle_%0d", n), bus.reg_out, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
